packet_rcv_ctrl: RTL and testbench

//  Receive-side peer of packet_ctrl. Responds to the link bring-up handshake and

---
 rtl/packet_rcv_ctrl.sv | 177 +++++++++++++++++
 tb/tb_packet_rcv_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/packet_rcv_ctrl.sv
// Receive side of the packet link: answers the bring-up handshake and reassembles
// PKT_LENGTH beats into one word held in a single-entry valid/ready buffer.
module packet_rcv_ctrl #(
    parameter int unsigned PKT_WIDTH  = 8,
    parameter int unsigned PKT_LENGTH = 4,
    parameter int unsigned LINK_DELAY = 3,
    localparam int unsigned DATA_WIDTH = PKT_WIDTH * PKT_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  link_req,
    input  logic                  link_down,
    output logic                  link_ack,
    output logic [1:0]            link_state,
    output logic                  pkt_req,
    input  logic [PKT_WIDTH-1:0]  pkt,
    input  logic                  pkt_sop,
    input  logic                  pkt_eop,
    output logic                  pkt_ack,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  err_len
);

    localparam int unsigned CW = $clog2(PKT_LENGTH) + 1;
    localparam int unsigned DW = $clog2(LINK_DELAY + 1);

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StBusy  = 2'b01,
        StReady = 2'b10,
        StUp    = 2'b11
    } link_st_e;

    link_st_e        state_q, state_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic            ack_q, ack_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pack_q, pack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  is_beat;

    // Link FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            dly_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            ack_q   <= ack_d;
        end
    end

    // Link FSM: next state
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        ack_d   = 1'b0;
        if (link_down) begin
            state_d = StInit;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (link_req) begin
                        state_d = StBusy;
                        dly_d   = DW'(LINK_DELAY - 1);
                    end
                end
                StBusy: begin
                    if (!link_req)        state_d = StInit;
                    else if (dly_q == '0) state_d = StReady;
                    else                  dly_d   = dly_q - 1'b1;
                end
                StReady: begin
                    if (link_req) begin
                        state_d = StUp;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = StInit;
                    end
                end
                StUp: state_d = StUp;
                default: state_d = StInit;
            endcase
        end
    end

    // Link FSM: outputs
    always_comb begin
        link_state = state_q;
        link_ack   = ack_q;
        pkt_req    = (state_q == StUp) && (cnt_q == '0) && (!valid_q || data_ready);
    end

    // No beat-valid strobe exists: a beat is any UP cycle carrying sop/eop or falling
    // inside an open packet, so idle cycles between packets are not errors.
    assign is_beat = (state_q == StUp) && !link_down && (pkt_sop || pkt_eop || cnt_q != '0);

    always_comb begin
        word = sr_q;
        word[(PKT_LENGTH-1)*PKT_WIDTH +: PKT_WIDTH] = pkt;
    end

    always_comb begin
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q && !data_ready;
        pack_d  = 1'b0;
        err_d   = 1'b0;
        if (link_down) begin
            cnt_d = '0;
        end else if (is_beat) begin
            if (pkt_sop && pkt_eop) begin
                err_d = 1'b1;
                cnt_d = '0;
            end else if (pkt_sop) begin
                err_d = (cnt_q != '0);
                cnt_d = CW'(1);
                sr_d[PKT_WIDTH-1:0] = pkt;
            end else if (cnt_q == '0) begin
                err_d = 1'b1;
            end else if (pkt_eop) begin
                cnt_d = '0;
                if (cnt_q != CW'(PKT_LENGTH - 1)) begin
                    err_d = 1'b1;
                end else if (valid_q && !data_ready) begin
                    err_d = 1'b1;
                end else begin
                    data_d  = word;
                    valid_d = 1'b1;
                    pack_d  = 1'b1;
                end
            end else if (cnt_q == CW'(PKT_LENGTH)) begin
                err_d = 1'b1;
                cnt_d = '0;
            end else begin
                for (int unsigned i = 1; i < PKT_LENGTH; i++) begin
                    if (cnt_q == CW'(i)) sr_d[i*PKT_WIDTH +: PKT_WIDTH] = pkt;
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign pkt_ack    = pack_q;
    assign err_len    = err_q;

endmodule

// File: tb/tb_packet_rcv_ctrl.sv
// Bench for packet_rcv_ctrl: directed scenarios then random traffic, all outputs
// compared every cycle against a packet-level reference model.
module tb_packet_rcv_ctrl;

    localparam int PW = 8;
    localparam int PL = 4;
    localparam int LD = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          link_req, link_down, link_ack;
    logic [1:0]    link_state;
    logic          pkt_req, pkt_sop, pkt_eop, pkt_ack;
    logic [PW-1:0] pkt;
    logic [31:0]   data;
    logic          data_valid, data_ready, err_len;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          run;
    bit          m_up, m_ack, m_pack, m_err, m_valid;
    bit [31:0]   m_data;
    bit [PW-1:0] beats[$];

    packet_rcv_ctrl #(.PKT_WIDTH(PW), .PKT_LENGTH(PL), .LINK_DELAY(LD)) dut (
        .clk(clk), .rst_n(rst_n), .link_req(link_req), .link_down(link_down),
        .link_ack(link_ack), .link_state(link_state), .pkt_req(pkt_req), .pkt(pkt),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_ack(pkt_ack), .data(data),
        .data_valid(data_valid), .data_ready(data_ready), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; m_up = 0; m_ack = 0; m_pack = 0; m_err = 0; m_valid = 0; m_data = 0;
        beats.delete();
    endtask

    // Link is up once link_req has been seen for LD+2 consecutive edges without teardown.
    task automatic model_step();
        bit was_up, pop, load;
        bit [31:0] w;
        was_up = m_up;
        pop = m_valid && data_ready;
        load = 0;
        w = 0;
        m_ack = 0; m_pack = 0; m_err = 0;
        if (link_down) begin
            run = 0; m_up = 0; beats.delete();
        end else begin
            if (!m_up) begin
                if (link_req) begin
                    run++;
                    if (run == LD + 2) begin m_up = 1; m_ack = 1; end
                end else run = 0;
            end
            if (was_up && (pkt_sop || pkt_eop || beats.size() != 0)) begin
                if (pkt_sop && pkt_eop) begin
                    m_err = 1; beats.delete();
                end else if (pkt_sop) begin
                    if (beats.size() != 0) m_err = 1;
                    beats.delete(); beats.push_back(pkt);
                end else if (beats.size() == 0) begin
                    m_err = 1;
                end else if (pkt_eop) begin
                    beats.push_back(pkt);
                    if (beats.size() != PL || (m_valid && !data_ready)) m_err = 1;
                    else begin
                        for (int i = 0; i < PL; i++) w[i*PW +: PW] = beats[i];
                        load = 1; m_pack = 1;
                    end
                    beats.delete();
                end else if (beats.size() == PL) begin
                    m_err = 1; beats.delete();
                end else beats.push_back(pkt);
            end
        end
        if (load) begin m_valid = 1; m_data = w; end
        else if (pop) m_valid = 0;
    endtask

    function automatic logic [1:0] exp_state();
        if (m_up) return 2'd3;
        if (run == 0) return 2'd0;
        if (run <= LD) return 2'd1;
        return 2'd2;
    endfunction

    task automatic check_outputs();
        check("link_state", 64'(link_state), 64'(exp_state()));
        check("link_ack", 64'(link_ack), 64'(m_ack));
        check("pkt_req", 64'(pkt_req),
              64'(m_up && beats.size() == 0 && (!m_valid || data_ready)));
        check("pkt_ack", 64'(pkt_ack), 64'(m_pack));
        check("err_len", 64'(err_len), 64'(m_err));
        check("data_valid", 64'(data_valid), 64'(m_valid));
        check("data", 64'(data), 64'(m_data));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic beat(input logic s, input logic e, input logic [PW-1:0] d);
        pkt_sop = s; pkt_eop = e; pkt = d;
        tick();
        pkt_sop = 0; pkt_eop = 0;
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 0; i < PL; i++) beat(i == 0, i == PL - 1, w[i*PW +: PW]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 64'(link_state), 64'd0);
        check({tag, "_flags"}, 64'({link_ack, pkt_req, pkt_ack, data_valid, err_len}), 64'd0);
        check({tag, "_data"}, 64'(data), 64'd0);
    endtask

    initial begin
        logic [1:0] bring_seq [5];
        int n;
        bring_seq = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        rst_n = 0; link_req = 0; link_down = 0; pkt = 0; pkt_sop = 0; pkt_eop = 0;
        data_ready = 0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        tick();

        // Bring-up with link_req held
        link_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bringup_seq", 64'(link_state), 64'(bring_seq[i]));
        end
        check("bringup_ack", 64'(link_ack), 64'd1);
        tick();
        check("ack_one_cycle", 64'(link_ack), 64'd0);

        // Good packet, held in buffer
        check("pkt_req_idle", 64'(pkt_req), 64'd1);
        beat(1, 0, 8'hA1); beat(0, 0, 8'hB2); beat(0, 0, 8'hC3); beat(0, 1, 8'hD4);
        check("good_data", 64'(data), 64'hD4C3B2A1);
        check("good_ack", 64'({data_valid, pkt_ack}), 64'b11);
        data_ready = 1; tick(); data_ready = 0;

        // Short packet, then a clean one
        beat(1, 0, 8'h11); beat(0, 0, 8'h22); beat(0, 1, 8'h33);
        check("short_err", 64'({err_len, data_valid}), 64'b10);
        send4(32'h44332211);
        check("after_short", 64'(data), 64'h44332211);

        // Backpressure: second packet dropped, held word unchanged
        tick();
        check("bp_pkt_req", 64'(pkt_req), 64'd0);
        send4(32'h88776655);
        check("bp_err", 64'(err_len), 64'd1);
        check("bp_data", 64'(data), 64'h44332211);

        // Back-to-back: pop exactly on the second eop
        data_ready = 1; tick(); data_ready = 0;
        send4(32'h0A0B0C0D);
        beat(1, 0, 8'h01); beat(0, 0, 8'h02); beat(0, 0, 8'h03);
        check("b2b_first", 64'(data), 64'h0A0B0C0D);
        data_ready = 1; beat(0, 1, 8'h04); data_ready = 0;
        check("b2b_second", 64'({data_valid, data}), {31'd0, 1'b1, 32'h04030201});

        // link_down mid-packet
        beat(1, 0, 8'h55); beat(0, 0, 8'h66);
        link_down = 1; tick(); link_down = 0;
        check("down_init", 64'({link_state, pkt_ack}), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("reup", 64'(link_state), 64'd3);
        data_ready = 1; send4(32'hCAFEF00D); data_ready = 0;
        check("reup_data", 64'(data), 64'hCAFEF00D);

        // Async reset mid-packet
        beat(1, 0, 8'h77); beat(0, 0, 8'h88);
        #2 rst_n = 0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) tick();

        // Random traffic
        for (int p = 0; p < 250; p++) begin
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++) begin
                data_ready = ($urandom_range(0, 2) != 0);
                link_down = ($urandom_range(0, 79) == 0);
                link_req = ($urandom_range(0, 59) != 0);
                beat((b == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0),
                     (b == n - 1) ? ($urandom_range(0, 7) != 0) : 1'b0,
                     PW'($urandom));
                link_down = 0;
            end
            link_req = 1;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                data_ready = $urandom_range(0, 1);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
